// File: rtl/spi_pkg.sv
// Shared SPI definitions for the slave port and the master-side sequencer.
package spi_pkg;

   localparam int                   SPI_WIDTH   = 8;
   localparam logic [SPI_WIDTH-1:0] SPI_IDLE_TX = 8'hFF;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchroniser with one extra registered copy for edge pulses.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_p0;
   logic                   dly_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= {SYNC_STAGES{RST_VAL}};
         dly_p1  <= RST_VAL;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
         dly_p1  <= sync_p0[SYNC_STAGES-1];
      end
   end

   // edge pulses are combinational so the consumer acts one clk after the sync output moves
   assign dout = sync_p0[SYNC_STAGES-1];
   assign rise = dout & ~dly_p1;
   assign fall = ~dout & dly_p1;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder: oversampled pins, MSB-first rx deserialiser and
// tx serialiser fed from a one-word holding buffer.
module spi_slave_port
   import spi_pkg::*;
#(
   parameter int               WIDTH       = SPI_WIDTH,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_TX     = SPI_IDLE_TX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_sigs;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk),
      .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst_n(rst_n), .din(cs_n),
      .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst_n(rst_n), .din(mosi),
      .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sigs = ^{sclk_s, mosi_rise, mosi_fall};

   spi_state_e       state_q, state_d;
   logic             start, stop, bit_rise, bit_fall, load, word_done, accept;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rx_shift, tx_shift, buf_data;
   logic             buf_full, reload_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // cs_n edges take priority: sclk edges are only honoured inside a stable frame
   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      stop     = 1'b0;
      bit_rise = 1'b0;
      bit_fall = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d = IDLE;
               stop    = 1'b1;
            end else begin
               bit_rise = sclk_rise;
               bit_fall = sclk_fall;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign load      = start | (bit_fall & reload_pending);
   assign word_done = bit_rise && (cnt == CNT_W'(WIDTH - 1));
   assign accept    = tx_valid & ~buf_full;
   assign tx_ready  = ~buf_full;
   assign miso      = miso_oe & tx_shift[WIDTH-1];
   assign busy      = ~cs_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         rx_shift       <= '0;
         tx_shift       <= '0;
         buf_data       <= '0;
         buf_full       <= 1'b0;
         reload_pending <= 1'b0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         tx_underrun    <= 1'b0;
         miso_oe        <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;

         // a load sees the buffer as it was; a same-cycle write refills it afterwards
         if (accept) begin
            buf_data <= tx_data;
            buf_full <= 1'b1;
         end else if (load && buf_full) begin
            buf_full <= 1'b0;
         end

         if (load) begin
            tx_shift       <= buf_full ? buf_data : IDLE_TX;
            tx_underrun    <= ~buf_full;
            reload_pending <= 1'b0;
         end else if (bit_fall) begin
            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
         end

         if (start) begin
            cnt     <= '0;
            miso_oe <= 1'b1;
         end

         if (stop) begin
            cnt            <= '0;
            reload_pending <= 1'b0;
            miso_oe        <= 1'b0;
            rx_shift       <= '0;
            tx_shift       <= '0;
         end

         if (bit_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
            if (word_done) begin
               rx_data        <= {rx_shift[WIDTH-2:0], mosi_s};
               rx_valid       <= 1'b1;
               cnt            <= '0;
               reload_pending <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
